// File: rtl/if_fetch_queue.sv
// if_fetch_queue: circular FIFO of {PC, instruction} pairs between IF and ID, flushed on taken branch.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hazard_freeze,
    input  logic [31:0]      PC_in,
    input  logic [31:0]      Instruction_in,
    output logic             if_freeze,
    output logic [31:0]      PC_out,
    output logic [31:0]      Instruction_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] count
);
    logic [63:0]      mem_q [DEPTH];
    logic [63:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    always_comb begin
        if_freeze = count_q == CNT_W'(DEPTH);
        valid_out = count_q != '0;
        push = !if_freeze && !flush;
        pop = valid_out && !hazard_freeze && !flush;
        wr_ptr_d = flush ? '0 : push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {PC_in, Instruction_in};
        // an empty queue feeds a zero bubble into ID regardless of stale storage
        {PC_out, Instruction_out} = valid_out ? mem_q[rd_ptr_q] : 64'h0;
        count = count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed and random stimulus checked against a queue-based model of the fetch queue.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic clk = 0, rst = 1, flush = 0, hazard_freeze = 0;
    logic [31:0] PC_in = 0, Instruction_in = 0;
    logic if_freeze, valid_out;
    logic [31:0] PC_out, Instruction_out;
    logic [CNT_W-1:0] count;
    int vectors = 0, miscompares = 0;
    logic [63:0] q[$];
    logic [CNT_W+65:0] dut_view;
    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hazard_freeze(hazard_freeze),
        .PC_in(PC_in), .Instruction_in(Instruction_in), .if_freeze(if_freeze),
        .PC_out(PC_out), .Instruction_out(Instruction_out), .valid_out(valid_out), .count(count)
    );
    always #5 clk = ~clk;
    assign dut_view = {valid_out, if_freeze, count, PC_out, Instruction_out};
    function automatic logic [CNT_W+65:0] model_view();
        return {q.size() != 0, q.size() == DEPTH, CNT_W'(q.size()), q.size() != 0 ? q[0] : 64'h0};
    endfunction
    // drive one cycle of inputs, advance the model at the edge, return at the following falling edge
    task automatic tick(input logic f, input logic h, input logic [31:0] pc, input logic [31:0] ins);
        logic do_push, do_pop;
        flush = f; hazard_freeze = h; PC_in = pc; Instruction_in = ins;
        @(posedge clk);
        if (f) q.delete();
        else begin
            do_push = q.size() != DEPTH;
            do_pop = q.size() != 0 && !h;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({pc, ins});
        end
        @(negedge clk);
    endtask
    task automatic test_reset();
        #1;
        vectors++;
        if (dut_view !== '0) begin
            miscompares++;
            $display("FAIL reset: dut=%h want=0", dut_view);
        end
        @(negedge clk);
        rst = 0;
        q.delete();
    endtask
    task automatic test_fill();
        for (int i = 0; i < 3; i++) tick(0, 1, 32'(i * 4), $urandom);
        vectors++;
        if (count !== 3 || valid_out !== 1 || PC_out !== 0 || if_freeze !== 0) begin
            miscompares++;
            $display("FAIL fill3: count=%0d valid=%b pc=%h freeze=%b want 3/1/0/0", count, valid_out, PC_out, if_freeze);
        end
        tick(0, 1, 32'd12, $urandom);
        vectors++;
        if (count !== 4 || if_freeze !== 1) begin
            miscompares++;
            $display("FAIL full: count=%0d freeze=%b want 4/1", count, if_freeze);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 32'd16, $urandom);
            vectors++;
            if (dut_view !== model_view() || count !== 4 || PC_out !== 0) begin
                miscompares++;
                $display("FAIL full_hold: dut=%h model=%h", dut_view, model_view());
            end
        end
    endtask
    task automatic test_drain_wrap();
        logic [31:0] next_pc = 16;
        logic [31:0] want [6] = '{4, 8, 12, 16, 20, 24};
        for (int i = 0; i < 6; i++) begin
            logic pushed;
            pushed = q.size() != DEPTH;
            tick(0, 0, next_pc, $urandom);
            if (pushed) next_pc += 4;
            vectors++;
            if (PC_out !== want[i] || count !== 3 || if_freeze !== 0 || dut_view !== model_view()) begin
                miscompares++;
                $display("FAIL drain_wrap[%0d]: pc=%h count=%0d freeze=%b want pc=%h count=3 freeze=0", i, PC_out, count, if_freeze, want[i]);
            end
        end
    endtask
    task automatic test_steady();
        logic [31:0] prev;
        tick(1, 0, 32'hdead, $urandom);
        for (int i = 0; i < 10; i++) begin
            prev = 32'h100 + 32'(i * 4);
            tick(0, 0, prev, $urandom);
            vectors++;
            if (PC_out !== prev || count !== 1 || dut_view !== model_view()) begin
                miscompares++;
                $display("FAIL steady[%0d]: pc=%h count=%0d want pc=%h count=1", i, PC_out, count, prev);
            end
        end
    endtask
    task automatic test_flush();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 32'h200 + 32'(i * 4), $urandom);
        vectors++;
        if (count !== 3) begin
            miscompares++;
            $display("FAIL flush_pre: count=%0d want 3", count);
        end
        tick(1, 1, 32'h40, 32'h1111);
        vectors++;
        if (count !== 0 || valid_out !== 0 || PC_out !== 0 || Instruction_out !== 0 || if_freeze !== 0) begin
            miscompares++;
            $display("FAIL flush: dut=%h want 0", dut_view);
        end
        tick(0, 0, 32'h80, 32'h2222);
        vectors++;
        if (PC_out !== 32'h80 || Instruction_out !== 32'h2222 || valid_out !== 1) begin
            miscompares++;
            $display("FAIL flush_target: pc=%h ins=%h valid=%b want 80/2222/1", PC_out, Instruction_out, valid_out);
        end
        tick(0, 0, 32'h84, 32'h3333);
        vectors++;
        if (PC_out !== 32'h84 || dut_view !== model_view()) begin
            miscompares++;
            $display("FAIL flush_after: pc=%h want 84", PC_out);
        end
    endtask
    task automatic test_async_reset();
        tick(1, 0, 0, 0);
        tick(0, 1, 32'h300, $urandom);
        tick(0, 1, 32'h304, $urandom);
        vectors++;
        if (count !== 2) begin
            miscompares++;
            $display("FAIL areset_pre: count=%0d want 2", count);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if (valid_out !== 0 || count !== 0 || if_freeze !== 0 || PC_out !== 0) begin
            miscompares++;
            $display("FAIL areset: valid=%b count=%0d freeze=%b pc=%h want all 0", valid_out, count, if_freeze, PC_out);
        end
        @(negedge clk);
        rst = 0;
        q.delete();
        tick(0, 1, 32'h500, 32'h5);
        vectors++;
        if (PC_out !== 32'h500 || count !== 1) begin
            miscompares++;
            $display("FAIL areset_resume: pc=%h count=%0d want 500/1", PC_out, count);
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0 ? ($urandom_range(0, 1) == 1) : 1'b1,
                 $urandom, $urandom);
            vectors++;
            if (dut_view !== model_view()) begin
                miscompares++;
                $display("FAIL random[%0d]: dut=%h model=%h", i, dut_view, model_view());
            end
        end
    endtask
    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_steady();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
